// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU selects, control FSM states and PC source codes.
// The ALU decodes AluOp using the same constants.
package cpu_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_SLL  = 4'hA;
  localparam logic [3:0] OP_SRL  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h4;
  localparam logic [3:0] ALU_SUB  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'hA;
  localparam logic [3:0] ALU_SRL  = 4'hB;
  localparam logic [3:0] ALU_LUI  = 4'hD;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEMORY    = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // R-type ops pass the opcode straight through; address and branch math reuse ADD/SUB.
  function automatic logic [3:0] alu_sel(input logic [3:0] op);
    logic [3:0] sel;
    sel = ALU_NONE;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_SUB, OP_CMP: sel = op;
      OP_LW, OP_SW, OP_ADDI: sel = ALU_ADD;
      OP_BEQ:                sel = ALU_SUB;
      OP_SLL:                sel = ALU_SLL;
      OP_SRL:                sel = ALU_SRL;
      OP_LUI:                sel = ALU_LUI;
      default:               sel = ALU_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Memory request/acknowledge bus between the control FSM and instruction/data memory.
interface control_fsm_if;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;

  modport master (output mem_req, output mem_we, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_rdata, output mem_ack);
endinterface

// File: rtl/control_fsm_mem_timeout_cnt.sv
// Memory wait watchdog: counts un-acked request cycles, flags the last allowed one.
module mem_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM. All outputs are registered or decoded from state and IR;
// strobes decided by an input (mem_ack, aluZero) appear in the cycle after the deciding edge.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  control_fsm_if.master        mem,
  input  logic                 aluZero,
  input  logic                 Overflow,
  output logic [3:0]           AluOp,
  output logic [15:0]          imm,
  output logic [3:0]           rd,
  output logic [3:0]           rs,
  output logic [3:0]           rt,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 regWrite,
  output logic [1:0]           pcSrc,
  output logic                 halted,
  output logic                 trap
);
  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        run_q;
  logic        irwr_q, irwr_d, pcwr_q, pcwr_d;
  logic [1:0]  pcsrc_q, pcsrc_d;
  logic        waiting, expired, ovf_trap, jump_now;
  logic [3:0]  op;

  assign op       = ir_q[31:28];
  assign waiting  = run_q && (state_q == ST_FETCH || state_q == ST_MEMORY);
  assign ovf_trap = Overflow && (op == OP_ADD || op == OP_SUB || op == OP_ADDI);

  // Counter restarts whenever a wait state is (re)entered rather than held.
  mem_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_cnt (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (!(waiting && state_d == state_q)),
    .inc_i     (waiting && !mem.mem_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    irwr_d  = 1'b0;
    pcwr_d  = 1'b0;
    pcsrc_d = PC_SEQ;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          if (mem.mem_ack) begin
            ir_d    = mem.mem_rdata;
            irwr_d  = 1'b1;
            pcwr_d  = 1'b1;
            state_d = ST_DECODE;
          end else if (expired) begin
            state_d = ST_TRAP;
          end
        end
        ST_DECODE: begin
          if (op == OP_HALT)   state_d = ST_HALT;
          else if (op == OP_J) state_d = ST_FETCH;
          else                 state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (ovf_trap) begin
            state_d = ST_TRAP;
          end else if (op == OP_BEQ) begin
            pcwr_d  = aluZero;
            pcsrc_d = aluZero ? PC_BRANCH : PC_SEQ;
            state_d = ST_FETCH;
          end else if (op == OP_LW || op == OP_SW) begin
            state_d = ST_MEMORY;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
        ST_MEMORY: begin
          if (mem.mem_ack)  state_d = (op == OP_SW) ? ST_FETCH : ST_WRITEBACK;
          else if (expired) state_d = ST_TRAP;
        end
        ST_WRITEBACK:     state_d = ST_FETCH;
        ST_HALT, ST_TRAP: state_d = state_q;
        default:          state_d = ST_TRAP;
      endcase
    end
  end

  // run_q keeps the bus quiet from reset until the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      run_q   <= 1'b0;
      irwr_q  <= 1'b0;
      pcwr_q  <= 1'b0;
      pcsrc_q <= PC_SEQ;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      run_q   <= 1'b1;
      irwr_q  <= irwr_d;
      pcwr_q  <= pcwr_d;
      pcsrc_q <= pcsrc_d;
    end
  end

  assign jump_now    = (state_q == ST_DECODE) && (op == OP_J);
  assign mem.mem_req = waiting;
  assign mem.mem_we  = run_q && (state_q == ST_MEMORY) && (op == OP_SW);

  assign AluOp    = (state_q inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) ? alu_sel(op) : ALU_NONE;
  assign imm      = ir_q[15:0];
  assign rd       = ir_q[27:24];
  assign rs       = ir_q[23:20];
  assign rt       = ir_q[19:16];
  assign irWrite  = irwr_q;
  assign pcWrite  = pcwr_q | jump_now;
  assign pcSrc    = jump_now ? PC_JUMP : pcsrc_q;
  assign regWrite = (state_q == ST_WRITEBACK);
  assign halted   = (state_q == ST_HALT);
  assign trap     = (state_q == ST_TRAP);
endmodule
